// File: rtl/seq_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// seq_shift_add_multiplier
//
// Multi-cycle WIDTH x WIDTH multiplier built from one adder. It processes one
// multiplier bit per clock, LSB first, and adds the shifted multiplicand
// magnitude into a 2*WIDTH accumulator. Signed operands are multiplied as
// magnitudes. The result is negated at the end when exactly one operand was
// negative. Square mode uses a as both operands.
//
// Timing for an accept at edge E0:
//   E0            IDLE -> CALC, operands captured
//   E0+1..E0+W    one multiplier bit per edge; the result lands in product
//                 on E0+W and the FSM enters DONE
//   E0+W+1        first edge at which a consumer sees out_valid=1
// With out_ready held high, one operation completes every WIDTH+2 cycles.
//
// Ports
//   clk        in   rising-edge clock for all state
//   reset      in   asynchronous, active-low reset
//   in_valid   in   operand set offered
//   in_ready   out  operand set accepted this cycle (IDLE only)
//   a          in   WIDTH   multiplicand
//   b          in   WIDTH   multiplier (ignored when square=1)
//   is_signed  in   1 = two's-complement operands and result
//   square     in   1 = compute a*a
//   out_valid  out  product holds a completed result (DONE)
//   out_ready  in   consumer takes the result this cycle
//   product    out  2*WIDTH result register
//   busy       out  high in CALC and DONE
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  input  logic               square,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            rst_sync_q, rst_sync_d;
  logic [PW-1:0]   mcand_q, mcand_d;     // multiplicand magnitude, shifts left each step
  logic [WIDTH-1:0] mplier_q, mplier_d;  // multiplier magnitude, shifts right each step
  logic [PW-1:0]   acc_q, acc_d;
  logic            neg_q, neg_d;         // result must be negated at the end
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   product_q, product_d;

  // ---------------------------------------------------------------------------
  // Operand conditioning (combinational, used only on the accept edge)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mplier_src;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    acc_sum;

  assign mplier_src = square ? a : b;
  assign a_neg      = is_signed & a[WIDTH-1];
  assign b_neg      = is_signed & mplier_src[WIDTH-1];

  // Negating -2^(WIDTH-1) in WIDTH bits gives the same bit pattern back. Read
  // as unsigned, that pattern is exactly the magnitude 2^(WIDTH-1), so no
  // extra bit is needed.
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~mplier_src + 1'b1) : mplier_src;

  // One shift-add step: add the multiplicand when the current multiplier bit is set.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // ---------------------------------------------------------------------------
  // Reset release synchroniser
  // ---------------------------------------------------------------------------
  // Reset asserts asynchronously. Its release takes effect on a clock edge.
  // Nothing can leave its reset value until in_ready opens, so the FSM and the
  // datapath all come out of reset in step with clk.
  assign rst_sync_d = 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 1'b0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    in_ready  = (state_q == IDLE) && rst_sync_q;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          neg_d    = a_neg ^ b_neg;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end

      CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // The last bit's sum goes straight to product, so the result is
          // ready on the WIDTH-th CALC edge.
          product_d = neg_q ? (~acc_sum + 1'b1) : acc_sum;
          cnt_d     = '0;
          state_d   = DONE;
        end
      end

      DONE: begin
        // product is left alone here and in IDLE. It holds the last result
        // until the next operation completes.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: the datapath registers are reset along with the FSM. When reset
  // aborts an operation, no partial accumulator or operand value survives to
  // leak into product later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every flop then
      // samples its pre-edge value, and the result does not depend on
      // statement order.
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// Testbench for seq_shift_add_multiplier (WIDTH=8).
// Inputs are driven 1 ns after the rising edge. Outputs are sampled on the
// falling edge or 1 ns after the rising edge. Each expected product is pushed
// to a scoreboard queue at the accept edge and popped when the output
// handshake is seen.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_seq_shift_add_multiplier;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          is_signed;
  logic          square;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .square    (square),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          s;
    logic          sq;
    logic [PW-1:0] exp;
  } vec_t;

  vec_t          vecs [14];
  logic [PW-1:0] sb [$];
  int            n_vec = 0;
  int            n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference product from plain integer arithmetic
  function automatic logic [PW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic ms, input logic msq);
    logic [W-1:0] bb;
    int           p;
    bb = msq ? ma : mb;
    if (ms) p = $signed(ma) * $signed(bb);
    else    p = int'({24'b0, ma}) * int'({24'b0, bb});
    return p[PW-1:0];
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 4 * W) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) check("out_valid_timeout", out_valid, 1);
  endtask

  // Offer one operand set. Return 1 ns after the accept edge with in_valid low
  // and the operand inputs scrambled.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic is, input logic isq, input logic [PW-1:0] exp);
    wait_ready();
    a = ia; b = ib; is_signed = is; square = isq; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(exp);
    #1;
    in_valid  = 1'b0;
    a         = W'($urandom);
    b         = W'($urandom);
    is_signed = ~is;
    square    = ~isq;
  endtask

  // Scoreboard monitor: the handshake happens on the next rising edge
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_unexpected_result", out_valid, 0);
      else                check("sb_product", product, sb.pop_front());
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] exp;
    logic [W-1:0]  ra, rb;
    logic          rs, rsq;
    time           t0, t1;
    int            n;

    vecs[0]  = '{8'd13, 8'd11, 1'b0, 1'b0, 16'h008F};
    vecs[1]  = '{8'hFD, 8'h05, 1'b1, 1'b0, 16'hFFF1};
    vecs[2]  = '{8'h80, 8'h80, 1'b1, 1'b0, 16'h4000};
    vecs[3]  = '{8'h80, 8'h01, 1'b1, 1'b0, 16'hFF80};
    vecs[4]  = '{8'hFF, 8'h00, 1'b0, 1'b1, 16'hFE01};
    vecs[5]  = '{8'hFF, 8'h37, 1'b1, 1'b1, 16'h0001};
    vecs[6]  = '{8'h00, 8'h00, 1'b0, 1'b0, 16'h0000};
    vecs[7]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01};
    vecs[8]  = '{8'h7F, 8'h80, 1'b1, 1'b0, 16'hC080};
    vecs[9]  = '{8'h80, 8'hFF, 1'b1, 1'b0, 16'h0080};
    vecs[10] = '{8'h80, 8'h7F, 1'b1, 1'b1, 16'h4000};
    vecs[11] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 16'h0001};
    vecs[12] = '{8'h7F, 8'h7F, 1'b1, 1'b0, 16'h3F01};
    vecs[13] = '{8'h80, 8'h80, 1'b0, 1'b0, 16'h4000};

    // ---------------- reset state ----------------
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; is_signed = 1'b0; square = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);

    // ---------------- latency: 13*11, out_valid seen at E0+9 ----------------
    issue(8'd13, 8'd11, 1'b0, 1'b0, 16'h008F);
    for (int k = 0; k < W; k++) begin
      check("lat_busy", busy, 1);
      check("lat_in_ready", in_ready, 0);
      check("lat_out_valid", out_valid, 0);
      @(posedge clk); #1;
    end
    check("lat_done_valid", out_valid, 1);
    check("lat_done_product", product, 16'h008F);
    @(posedge clk); #1;
    check("lat_after_hs_valid", out_valid, 0);
    check("lat_after_hs_in_ready", in_ready, 1);
    check("lat_after_hs_product", product, 16'h008F);

    // ---------------- table vectors ----------------
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].sq, vecs[i].exp);
      wait_done();
    end

    // ---------------- random vectors ----------------
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      rs = 1'($urandom); rsq = ($urandom_range(0, 3) == 0);
      issue(ra, rb, rs, rsq, model(ra, rb, rs, rsq));
      wait_done();
    end

    // ---------------- backpressure ----------------
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp = model(8'hC3, 8'h5A, 1'b1, 1'b0);
    issue(8'hC3, 8'h5A, 1'b1, 1'b0, exp);
    in_valid = 1'b1; a = 8'h11; b = 8'h22;  // offered during CALC/DONE: ignored
    wait_done();
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_product", product, exp);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_in_ready", in_ready, 1);
    check("bp_idle_busy", busy, 0);
    check("bp_idle_out_valid", out_valid, 0);
    check("bp_idle_product", product, exp);
    repeat (3) @(posedge clk);
    #1;
    check("bp_nothing_queued", busy, 0);

    // ---------------- reset in the 4th CALC cycle ----------------
    issue(8'd200, 8'd150, 1'b0, 1'b0, model(8'd200, 8'd150, 1'b0, 1'b0));
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_product", product, 0);
    check("abort_busy", busy, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("abort_release_in_ready", in_ready, 1);
    issue(8'd2, 8'd3, 1'b0, 1'b0, 16'h0006);
    wait_done();
    check("abort_next_product", product, 16'h0006);

    // ---------------- back-to-back ----------------
    @(posedge clk); #1;
    out_ready = 1'b1;
    a = 8'd7; b = 8'd9; is_signed = 1'b0; square = 1'b0; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    @(posedge clk);
    t0 = $time;
    sb.push_back(16'h003F);
    #1;
    a = 8'd255; b = 8'd255;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    @(posedge clk);
    t1 = $time;
    sb.push_back(16'hFE01);
    #1;
    in_valid = 1'b0;
    check("b2b_accept_spacing", 64'((t1 - t0) / 10), 10);

    // ---------------- drain ----------------
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
